// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD up-timer: digit width, largest legal digit,
// the control FSM state encoding and small digit helper functions.
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int                 DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True when the nibble encodes a legal decimal digit (0..9).
  function automatic logic bcd_digit_valid(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_MAX);
  endfunction

  // Illegal digits (A..F) saturate to 9 so a clamped value is always BCD.
  function automatic logic [DIGIT_W-1:0] bcd_digit_clamp(input logic [DIGIT_W-1:0] d);
    return bcd_digit_valid(d) ? d : DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One registered BCD digit, chained with its neighbours through a ripple carry.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset, digit -> 0
//   i_clr        synchronous clear to 0 (highest synchronous priority)
//   i_load       synchronous load of i_load_d
//   i_load_d     value to load (caller guarantees it is a legal digit)
//   i_inc_en     global increment enable for the whole chain
//   i_carry_in   carry from the less significant digit (1 for digit 0)
//   o_digit      current digit value
//   o_carry_out  this digit will roll 9 -> 0 if the chain increments
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_load_d,
  input  logic               i_inc_en,
  input  logic               i_carry_in,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_carry_out
);

  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= '0;
    end else if (i_clr) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_d;
    end else if (i_inc_en && i_carry_in) begin
      r_digit <= (r_digit == DIGIT_MAX) ? '0 : r_digit + 1'b1;
    end
  end

  // Carry is purely combinational from the registered digit, so the ripple
  // chain settles within one cycle without any feedback through i_inc_en.
  assign o_carry_out = i_carry_in && (r_digit == DIGIT_MAX);
  assign o_digit     = r_digit;

endmodule

// File: rtl/bcd_up_timer.sv
// -----------------------------------------------------------------------------
// bcd_up_timer
// Multi-digit BCD up-counter with preset load, terminal limit and a small
// IDLE / RUN / HOLD / DONE control FSM.
//
// Parameters
//   DIGITS  number of BCD digits (default 4)
//   WRAP    1: restart from 0 at limit, 0: stop at limit and enter DONE
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   load_valid   load request; accepted when load_ready is high
//   load_ready   high in IDLE, HOLD, DONE
//   load_data    BCD preset, digit 0 in bits [3:0]; any digit >9 is rejected
//   limit        BCD terminal value, captured (digits clamped to 9) on start
//   start/stop   begin/resume and pause; stop wins when both are high
//   tick         count enable, one increment per cycle while in RUN
//   bcd_out      registered BCD count
//   carry_out    one-cycle pulse aligned with the update at the limit
//   running      high in RUN
//   done         high in DONE
//   err          one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module bcd_up_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DIGITS*4-1:0]   load_data,
  input  logic [DIGITS*4-1:0]   limit,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  carry_out,
  output logic                  running,
  output logic                  done,
  output logic                  err
);

  localparam int W = DIGITS * DIGIT_W;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_limit;
  logic            r_carry;
  logic            r_err;

  logic [W-1:0]    w_count;
  logic [W-1:0]    w_limit_clamp;
  logic [DIGITS-1:0] w_digit_ok;
  logic [DIGITS:0] w_carry;
  logic            w_load_fire;
  logic            w_load_ok;
  logic            w_load_acc;
  logic            w_start_acc;
  logic            w_at_limit;
  logic            w_run_tick;
  logic            w_inc;
  logic            w_hit;
  logic            w_clr;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_load_fire = load_valid && load_ready;
  assign w_load_ok   = &w_digit_ok;
  assign w_load_acc  = w_load_fire && w_load_ok;

  // A start is only honoured outside RUN and never together with stop.
  assign w_start_acc = start && !stop && (r_state != ST_RUN);

  assign w_at_limit  = (w_count == r_limit);
  assign w_run_tick  = (r_state == ST_RUN) && tick;
  assign w_inc       = w_run_tick && !w_at_limit;
  assign w_hit       = w_run_tick && w_at_limit;

  // Clear sources: wrap at the limit, restart out of DONE (unless a load in
  // the same cycle supplies the new value), and all-9s rollover. The rollover
  // term matches what the digit chain does on its own; stating it here keeps
  // the top-level carry meaningful and the behaviour explicit.
  assign w_carry[0]  = 1'b1;
  assign w_clr       = (w_hit && WRAP)
                    || ((r_state == ST_DONE) && w_start_acc && !w_load_acc)
                    || (w_inc && w_carry[DIGITS]);

  // ---------------------------------------------------------------------------
  // Digit chain, per-digit load validation and limit clamping
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_load      (w_load_acc),
        .i_load_d    (load_data[gi*DIGIT_W +: DIGIT_W]),
        .i_inc_en    (w_inc),
        .i_carry_in  (w_carry[gi]),
        .o_digit     (w_count[gi*DIGIT_W +: DIGIT_W]),
        .o_carry_out (w_carry[gi+1])
      );

      assign w_digit_ok[gi] = bcd_digit_valid(load_data[gi*DIGIT_W +: DIGIT_W]);
      assign w_limit_clamp[gi*DIGIT_W +: DIGIT_W] =
        bcd_digit_clamp(limit[gi*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Limit capture and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_limit <= {DIGITS{DIGIT_MAX}};
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_limit <= w_limit_clamp;
      end
      r_carry <= w_hit;
      r_err   <= w_load_fire && !w_load_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_start_acc) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A tick in the same cycle as stop is still counted by the datapath.
        if (stop) begin
          w_state_next = ST_HOLD;
        end else if (w_hit && !WRAP) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_start_acc) begin
          w_state_next = ST_RUN;
        end else if (w_load_acc) begin
          w_state_next = ST_HOLD;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs, decoded from the registered state only
  always_comb begin
    running    = 1'b0;
    done       = 1'b0;
    load_ready = 1'b1;
    case (r_state)
      ST_RUN: begin
        running    = 1'b1;
        load_ready = 1'b0;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bcd_out   = w_count;
  assign carry_out = r_carry;
  assign err       = r_err;

endmodule
